// File: rtl/multicycle_ctrl_if.sv
// Handshake and datapath-control bundle between the multicycle sequencer and the
// IR/PC/ALU datapath plus the instruction and data memories.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic       start;
    logic [5:0] op;
    logic       branch_flag;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       jump;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       busy;
    logic       halted;
    logic       timeout_err;
    logic [2:0] state;

    modport master (
        input  start, op, branch_flag, imem_ready, dmem_ready,
        output imem_req, dmem_req, ir_write, pc_write, pc_src, jump, mem_write,
               mem_to_reg, alu_src, reg_write, alu_control, busy, halted,
               timeout_err, state
    );

    modport slave (
        output start, op, branch_flag, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ir_write, pc_write, pc_src, jump, mem_write,
               mem_to_reg, alu_src, reg_write, alu_control, busy, halted,
               timeout_err, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM sequencer for the accumulator CPU: per-state datapath enables from op/branch_flag.
// Latency: ALU/imm 4, load 5, store 4, branch 3, jump 2 cycles when memories answer at once.
// Backpressure: FETCH/MEM hold on imem_ready/dmem_ready; a watchdog halts after TIMEOUT wait cycles.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_set, err_clr;

    logic       imem_req, dmem_req, ir_write, pc_write, pc_src, jump;
    logic       mem_write, mem_to_reg, alu_src, reg_write;
    logic [2:0] alu_control;

    // op[5:4] selects the instruction class; op[3:0] sub-decodes the control class
    logic [1:0] op_class;
    logic [3:0] op_sub;
    assign op_class = bus.op[5:4];
    assign op_sub   = bus.op[3:0];

    // State, wait counter and sticky watchdog flag; async reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Next state and per-state strobes; the counter only survives while a wait continues
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        jump        = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        alu_control = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (op_class != 2'b11 || op_sub == 4'b0000) begin
                    state_d = S_EXEC;
                end else if (op_sub == 4'b0001) begin
                    pc_write = 1'b1;
                    jump     = 1'b1;
                    state_d  = S_FETCH;
                end else if (op_sub == 4'b1111) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_class)
                    2'b00: begin
                        alu_control = bus.op[2:0];
                        state_d     = S_WB;
                    end
                    2'b01: begin
                        alu_control = bus.op[2:0];
                        alu_src     = 1'b1;
                        state_d     = S_WB;
                    end
                    2'b10: begin
                        alu_control = 3'b000;
                        alu_src     = 1'b1;
                        state_d     = S_MEM;
                    end
                    default: begin
                        alu_control = 3'b001;
                        pc_write    = bus.branch_flag;
                        pc_src      = bus.branch_flag;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (bus.dmem_ready) begin
                    mem_write = bus.op[0];
                    state_d   = bus.op[0] ? S_FETCH : S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_write = bus.op[0];
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_class == 2'b10) && !bus.op[0];
                state_d    = S_FETCH;
            end
            S_HALT: begin
                if (bus.start) begin
                    err_clr = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.dmem_req    = dmem_req;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.pc_src      = pc_src;
    assign bus.jump        = jump;
    assign bus.mem_write   = mem_write;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.alu_src     = alu_src;
    assign bus.reg_write   = reg_write;
    assign bus.alu_control = alu_control;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.timeout_err = err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces built
// from the instruction-class rules, random memory latencies and random don't-care inputs.
// Directed cases cover reset, timeout boundaries, halt/restart and async abort in MEM.
module tb_multicycle_ctrl;
    localparam int TIMEOUT = 16;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

    typedef struct packed {
        logic [2:0] state;
        logic busy, halted, timeout_err, imem_req, dmem_req, ir_write, pc_write;
        logic pc_src, jump, mem_write, mem_to_reg, alu_src, reg_write;
        logic [2:0] alu_control;
    } outs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic terr_m   = 1'b0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.state       = bus.state;
        o.busy        = bus.busy;
        o.halted      = bus.halted;
        o.timeout_err = bus.timeout_err;
        o.imem_req    = bus.imem_req;
        o.dmem_req    = bus.dmem_req;
        o.ir_write    = bus.ir_write;
        o.pc_write    = bus.pc_write;
        o.pc_src      = bus.pc_src;
        o.jump        = bus.jump;
        o.mem_write   = bus.mem_write;
        o.mem_to_reg  = bus.mem_to_reg;
        o.alu_src     = bus.alu_src;
        o.reg_write   = bus.reg_write;
        o.alu_control = bus.alu_control;
        return o;
    endfunction

    // Quiet outputs of a state: only status flags, every strobe low
    function automatic outs_t base(input logic [2:0] st);
        outs_t o = '0;
        o.state       = st;
        o.busy        = (st >= ST_FETCH) && (st <= ST_WB);
        o.halted      = (st == ST_HALT);
        o.timeout_err = terr_m;
        return o;
    endfunction

    // Drive one cycle of inputs just after the edge, compare at the falling edge
    task automatic step(input string tag, input logic st, input logic [5:0] op_v,
                        input logic br, input logic ir, input logic dr, input outs_t exp);
        bus.start       = st;
        bus.op          = op_v;
        bus.branch_flag = br;
        bus.imem_ready  = ir;
        bus.dmem_ready  = dr;
        @(negedge clk);
        check(tag, 32'(observe()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // Whole instruction from FETCH; di/dd are memory wait cycles (>= TIMEOUT means never ready)
    task automatic run_instr(input logic [5:0] op_v, input logic br, input int di,
                             input int dd, output logic halted_o);
        outs_t      o;
        logic [1:0] cls;
        logic [3:0] sub;
        cls      = op_v[5:4];
        sub      = op_v[3:0];
        halted_o = 1'b0;
        for (int k = 0; k < di && k < TIMEOUT - 1; k++) begin
            o = base(ST_FETCH); o.imem_req = 1'b1;
            step("fetch_wait", rbit(), rop(), rbit(), 1'b0, rbit(), o);
        end
        if (di >= TIMEOUT) begin
            o = base(ST_FETCH); o.imem_req = 1'b1;
            step("fetch_timeout", rbit(), rop(), rbit(), 1'b0, rbit(), o);
            terr_m = 1'b1; halted_o = 1'b1;
            return;
        end
        o = base(ST_FETCH); o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        step("fetch", rbit(), rop(), rbit(), 1'b1, rbit(), o);

        o = base(ST_DECODE);
        if (cls == 2'd3 && sub == 4'd1) begin o.pc_write = 1'b1; o.jump = 1'b1; end
        step("decode", rbit(), op_v, rbit(), rbit(), rbit(), o);
        if (cls == 2'd3 && sub != 4'd0) begin
            halted_o = (sub == 4'hf);
            return;
        end

        o = base(ST_EXEC);
        case (cls)
            2'd0: o.alu_control = op_v[2:0];
            2'd1: begin o.alu_control = op_v[2:0]; o.alu_src = 1'b1; end
            2'd2: o.alu_src = 1'b1;
            default: begin o.alu_control = 3'b001; o.pc_write = br; o.pc_src = br; end
        endcase
        step("exec", rbit(), op_v, br, rbit(), rbit(), o);
        if (cls == 2'd3) return;

        if (cls == 2'd2) begin
            for (int k = 0; k < dd && k < TIMEOUT - 1; k++) begin
                o = base(ST_MEM); o.dmem_req = 1'b1; o.mem_write = op_v[0];
                step("mem_wait", rbit(), op_v, rbit(), rbit(), 1'b0, o);
            end
            if (dd >= TIMEOUT) begin
                o = base(ST_MEM); o.dmem_req = 1'b1;
                step("mem_timeout", rbit(), op_v, rbit(), rbit(), 1'b0, o);
                terr_m = 1'b1; halted_o = 1'b1;
                return;
            end
            o = base(ST_MEM); o.dmem_req = 1'b1; o.mem_write = op_v[0];
            step("mem", rbit(), op_v, rbit(), rbit(), 1'b1, o);
            if (op_v[0]) return;
        end

        o = base(ST_WB); o.reg_write = 1'b1; o.mem_to_reg = (cls == 2'd2);
        step("wb", rbit(), op_v, rbit(), rbit(), rbit(), o);
    endtask

    // Sit in HALT for a few cycles, then relaunch; start clears the sticky error
    task automatic restart_from_halt();
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            step("halt_hold", 1'b0, rop(), rbit(), rbit(), rbit(), base(ST_HALT));
        end
        step("halt_start", 1'b1, rop(), rbit(), rbit(), rbit(), base(ST_HALT));
        terr_m = 1'b0;
    endtask

    function automatic int pick_delay();
        int r = $urandom_range(0, 9);
        if (r < 7)  return $urandom_range(0, 3);
        if (r == 7) return TIMEOUT - 1;
        if (r == 8) return TIMEOUT - 2;
        return TIMEOUT;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic  h;
        outs_t o;
        bus.start = 1'b1; bus.op = rop(); bus.branch_flag = 1'b1;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2 check("reset_async", 32'(observe()), 32'(outs_t'('0)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", 32'(observe()), 32'(outs_t'('0)));
        @(posedge clk); #1;
        rst_n = 1'b1;

        step("idle", 1'b0, rop(), rbit(), rbit(), rbit(), base(ST_IDLE));
        step("idle", 1'b0, rop(), rbit(), rbit(), rbit(), base(ST_IDLE));
        step("idle_start", 1'b1, rop(), rbit(), rbit(), rbit(), base(ST_IDLE));

        run_instr(6'b000010, rbit(), 0, 0, h);           // ALU reg, 4 cycles
        run_instr(6'b100000, rbit(), 0, 3, h);           // load, MEM held 4 cycles
        run_instr(6'b110000, 1'b1, 0, 0, h);             // branch taken
        run_instr(6'b110000, 1'b0, 0, 0, h);             // branch not taken
        run_instr(6'b100001, rbit(), 1, 2, h);           // store
        run_instr(6'b010101, rbit(), 2, 0, h);           // ALU immediate
        run_instr(6'b110001, rbit(), 0, 0, h);           // jump
        run_instr(6'b110110, rbit(), 0, 0, h);           // NOP
        run_instr(6'b000111, rbit(), TIMEOUT - 1, 0, h); // ready on last wait cycle wins
        run_instr(6'b100000, rbit(), 0, TIMEOUT - 1, h);
        run_instr(6'b000001, rbit(), TIMEOUT, 0, h);     // fetch timeout
        if (h) restart_from_halt();
        else check("fetch_timeout_halts", 32'(h), 32'(1));
        run_instr(6'b111111, rbit(), 0, 0, h);           // halt
        if (h) restart_from_halt();
        else check("halt_op_halts", 32'(h), 32'(1));
        run_instr(6'b100001, rbit(), 0, TIMEOUT, h);     // store timeout in MEM
        if (h) restart_from_halt();
        else check("mem_timeout_halts", 32'(h), 32'(1));

        for (int n = 0; n < 150; n++) begin
            run_instr(rop(), rbit(), pick_delay(), pick_delay(), h);
            if (h) restart_from_halt();
        end

        // Store caught in MEM by an asynchronous reset
        o = base(ST_FETCH); o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        step("fetch", 1'b0, rop(), rbit(), 1'b1, rbit(), o);
        step("decode", 1'b0, 6'b100001, rbit(), rbit(), rbit(), base(ST_DECODE));
        o = base(ST_EXEC); o.alu_src = 1'b1;
        step("exec", 1'b0, 6'b100001, rbit(), rbit(), rbit(), o);
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        o = base(ST_MEM); o.dmem_req = 1'b1; o.mem_write = 1'b1;
        check("mem_before_abort", 32'(observe()), 32'(o));
        #2 rst_n = 1'b0;
        #1 check("abort_async", 32'(observe()), 32'(outs_t'('0)));
        terr_m = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("idle_after_abort", 1'b0, rop(), rbit(), rbit(), rbit(), base(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
